// File: rtl/gcn_layer_sequencer_if.sv
// Handshake and data bundle between the GCN layer sequencer and its environment:
// system start/done/busy/error, the transformation block start/done, the
// product-memory row port and the per-node class results.
interface gcn_layer_sequencer_if #(
  parameter int FEATURE_ROWS          = 6,
  parameter int WEIGHT_COLS           = 3,
  parameter int DOT_PROD_WIDTH        = 16,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int CLASS_WIDTH           = $clog2(WEIGHT_COLS)
);
  logic                             start;
  logic                             trans_start;
  logic                             done_trans;
  logic [COUNTER_FEATURE_WIDTH-1:0] read_row;
  logic [DOT_PROD_WIDTH-1:0]        fm_wm_row_in [0:WEIGHT_COLS-1];
  logic [CLASS_WIDTH-1:0]           y [0:FEATURE_ROWS-1];
  logic                             done;
  logic                             busy;
  logic                             error;

  // Sequencer side
  modport master (
    input  start, done_trans, fm_wm_row_in,
    output trans_start, read_row, y, done, busy, error
  );

  // Environment side (system controller, transformation block, product memory)
  modport slave (
    output start, done_trans, fm_wm_row_in,
    input  trans_start, read_row, y, done, busy, error
  );
endinterface

// File: rtl/gcn_layer_sequencer.sv
// GCN layer pass controller: launches the transformation, then sweeps the product
// memory one row per cycle and stores the argmax class of each row in y.
// Optional TRANS watchdog enabled by defining GCN_SEQ_TIMEOUT_EN.
module gcn_layer_sequencer #(
  parameter int FEATURE_ROWS          = 6,
  parameter int WEIGHT_COLS           = 3,
  parameter int DOT_PROD_WIDTH        = 16,
  parameter int COUNTER_FEATURE_WIDTH = $clog2(FEATURE_ROWS),
  parameter int CLASS_WIDTH           = $clog2(WEIGHT_COLS),
  parameter int TIMEOUT_CYCLES        = 1024
) (
  input  logic                  clk,
  input  logic                  reset,
  gcn_layer_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_TRANS,
    S_READ,
`ifdef GCN_SEQ_TIMEOUT_EN
    S_DONE,
    S_ERROR
`else
    S_DONE
`endif
  } state_t;

  localparam logic [COUNTER_FEATURE_WIDTH-1:0] LAST_ROW = COUNTER_FEATURE_WIDTH'(FEATURE_ROWS - 1);

  state_t                           state;
  state_t                           state_nxt;
  logic [COUNTER_FEATURE_WIDTH-1:0] row_cnt;
  logic [CLASS_WIDTH-1:0]           y_q [0:FEATURE_ROWS-1];
  logic [CLASS_WIDTH-1:0]           row_max_idx;
  logic [DOT_PROD_WIDTH-1:0]        row_max_val;

`ifdef GCN_SEQ_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] trans_cnt;
  logic          timeout_hit;

  // Count cycles spent in TRANS; cleared whenever the FSM is elsewhere
  always_ff @(posedge clk) begin
    if (reset || state != S_TRANS) trans_cnt <= '0;
    else                           trans_cnt <= trans_cnt + 1'b1;
  end

  // Last permitted TRANS cycle; a done_trans here still wins over the timeout
  assign timeout_hit = (trans_cnt == TW'(TIMEOUT_CYCLES - 1));
`endif

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (bus.start) state_nxt = S_TRANS;
      S_TRANS: begin
        if (bus.done_trans) state_nxt = S_READ;
`ifdef GCN_SEQ_TIMEOUT_EN
        else if (timeout_hit) state_nxt = S_ERROR;
`endif
      end
      S_READ:  if (row_cnt == LAST_ROW) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
`ifdef GCN_SEQ_TIMEOUT_EN
      S_ERROR: state_nxt = S_ERROR;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    bus.trans_start = (state == S_TRANS);
    bus.done        = (state == S_DONE);
    bus.busy        = (state != S_IDLE);
`ifdef GCN_SEQ_TIMEOUT_EN
    bus.error       = (state == S_ERROR);
`else
    bus.error       = 1'b0;
`endif
  end

  // Argmax over the current row: strict greater-than keeps the lowest index on ties
  always_comb begin
    row_max_idx = '0;
    row_max_val = bus.fm_wm_row_in[0];
    for (int c = 1; c < WEIGHT_COLS; c++) begin
      if (bus.fm_wm_row_in[c] > row_max_val) begin
        row_max_val = bus.fm_wm_row_in[c];
        row_max_idx = CLASS_WIDTH'(c);
      end
    end
  end

  // Row sweep and result storage; row counter sits at 0 outside READ so it doubles as read_row
  always_ff @(posedge clk) begin
    if (reset) begin
      row_cnt <= '0;
      for (int i = 0; i < FEATURE_ROWS; i++) y_q[i] <= '0;
    end else if (state == S_READ) begin
      y_q[row_cnt] <= row_max_idx;
      row_cnt      <= (row_cnt == LAST_ROW) ? '0 : row_cnt + 1'b1;
    end else begin
      row_cnt <= '0;
    end
  end

  assign bus.read_row = row_cnt;
  assign bus.y        = y_q;

endmodule

// File: tb/tb_gcn_layer_sequencer.sv
// Self-checking bench for gcn_layer_sequencer: randomized product rows checked
// against a max-then-first-index argmax model, cycle-exact handshake timing.
module tb_gcn_layer_sequencer;
  localparam int FR = 6;
  localparam int WC = 3;
  localparam int DW = 16;
  localparam int RW = $clog2(FR);
  localparam int CW = $clog2(WC);
`ifdef GCN_SEQ_TIMEOUT_EN
  localparam int MAXW = 15;
`else
  localparam int MAXW = 40;
`endif

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gcn_layer_sequencer_if #(.FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW)) bus ();

  gcn_layer_sequencer #(
    .FEATURE_ROWS(FR), .WEIGHT_COLS(WC), .DOT_PROD_WIDTH(DW), .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  logic [DW-1:0] mem [0:7][0:WC-1];
  int exp_y [0:FR-1];
  int checks = 0;
  int errors = 0;

  // Product memory: combinational read of the selected row
  always_comb begin
    for (int c = 0; c < WC; c++) bus.fm_wm_row_in[c] = mem[bus.read_row][c];
  end

  // Reference argmax: find the maximum value, then the first column holding it
  function automatic int ref_class(int r);
    logic [DW-1:0] best;
    best = '0;
    for (int c = 0; c < WC; c++) if (mem[r][c] > best) best = mem[r][c];
    for (int c = 0; c < WC; c++) if (mem[r][c] == best) return c;
    return 0;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load_random();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < WC; c++)
        mem[r][c] = ($urandom_range(0, 1) == 1) ? DW'($urandom_range(0, 3)) : DW'($urandom);
  endtask

  task automatic launch();
    for (int i = 0; i < FR; i++) begin
      checks++;
      if (bus.y[i] !== CW'(exp_y[i])) begin
        errors++;
        $display("FAIL y_hold_idle row %0d got %0d want %0d", i, bus.y[i], exp_y[i]);
      end
    end
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    checks++;
    if (bus.busy !== 1'b1 || bus.trans_start !== 1'b1) begin
      errors++;
      $display("FAIL launch busy=%b trans_start=%b want 1 1", bus.busy, bus.trans_start);
    end
  endtask

  // Wait `delay` more TRANS cycles, finish the transformation, then check the whole sweep
  task automatic read_phase(int delay, bit poke, bit hold_at_done);
    for (int i = 0; i < delay; i++) begin
      if (poke) bus.start = 1'($urandom_range(0, 1));
      step();
      checks++;
      if (bus.trans_start !== 1'b1 || bus.done !== 1'b0 || bus.read_row !== '0 || bus.error !== 1'b0) begin
        errors++;
        $display("FAIL trans_wait cyc %0d trans_start=%b done=%b read_row=%0d error=%b want 1 0 0 0",
                 i, bus.trans_start, bus.done, bus.read_row, bus.error);
      end
    end
    bus.done_trans = 1'b1;
    step();
    bus.done_trans = 1'b0;
    for (int k = 0; k < FR; k++) begin
      if (poke) bus.start = 1'($urandom_range(0, 1));
      checks++;
      if (bus.read_row !== RW'(k) || bus.trans_start !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b1) begin
        errors++;
        $display("FAIL read_step k=%0d read_row=%0d trans_start=%b done=%b busy=%b want %0d 0 0 1",
                 k, bus.read_row, bus.trans_start, bus.done, bus.busy, k);
      end
      step();
      checks++;
      if (bus.y[k] !== CW'(ref_class(k))) begin
        errors++;
        $display("FAIL y_row %0d got %0d want %0d", k, bus.y[k], ref_class(k));
      end
    end
    bus.start = hold_at_done;
    checks++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b1 || bus.read_row !== '0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL done_pulse done=%b busy=%b read_row=%0d error=%b want 1 1 0 0",
               bus.done, bus.busy, bus.read_row, bus.error);
    end
    for (int i = 0; i < FR; i++) begin
      checks++;
      if (bus.y[i] !== CW'(ref_class(i))) begin
        errors++;
        $display("FAIL y_at_done row %0d got %0d want %0d", i, bus.y[i], ref_class(i));
      end
    end
    step();
    checks++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL done_end done=%b busy=%b want 0 0", bus.done, bus.busy);
    end
    for (int i = 0; i < FR; i++) exp_y[i] = ref_class(i);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    step();
    checks++;
    if (bus.trans_start !== 1'b0 || bus.read_row !== '0 || bus.done !== 1'b0 ||
        bus.busy !== 1'b0 || bus.error !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs trans_start=%b read_row=%0d done=%b busy=%b error=%b want all 0",
               bus.trans_start, bus.read_row, bus.done, bus.busy, bus.error);
    end
    for (int i = 0; i < FR; i++) begin
      exp_y[i] = 0;
      checks++;
      if (bus.y[i] !== '0) begin
        errors++;
        $display("FAIL reset_y row %0d got %0d want 0", i, bus.y[i]);
      end
    end
    reset = 1'b0;
    step();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release busy=%b want 0", bus.busy);
    end
  endtask

  task automatic test_basic();
    int want [0:FR-1];
    want = '{2, 2, 2, 1, 1, 1};
    for (int r = 0; r < 8; r++) begin
      mem[r][0] = DW'(r);
      mem[r][1] = DW'(2 * r);
      mem[r][2] = DW'(5);
    end
    launch();
    read_phase((MAXW < 19) ? MAXW : 19, 1'b0, 1'b0);
    for (int i = 0; i < FR; i++) begin
      checks++;
      if (bus.y[i] !== CW'(want[i])) begin
        errors++;
        $display("FAIL basic_y row %0d got %0d want %0d", i, bus.y[i], want[i]);
      end
    end
  endtask

  task automatic test_ties();
    int want [0:3];
    want = '{0, 0, 0, 2};
    load_random();
    mem[0][0] = 16'd7;    mem[0][1] = 16'd7;    mem[0][2] = 16'd3;
    mem[1][0] = 16'd0;    mem[1][1] = 16'd0;    mem[1][2] = 16'd0;
    mem[2][0] = 16'hFFFF; mem[2][1] = 16'h8000; mem[2][2] = 16'hFFFF;
    mem[3][0] = 16'd1;    mem[3][1] = 16'd2;    mem[3][2] = 16'hFFFF;
    launch();
    read_phase($urandom_range(0, MAXW), 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (bus.y[i] !== CW'(want[i])) begin
        errors++;
        $display("FAIL ties_y row %0d got %0d want %0d", i, bus.y[i], want[i]);
      end
    end
  endtask

  task automatic test_ignored_inputs();
    bus.done_trans = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (bus.busy !== 1'b0 || bus.trans_start !== 1'b0 || bus.read_row !== '0) begin
        errors++;
        $display("FAIL done_trans_idle busy=%b trans_start=%b read_row=%0d want 0 0 0",
                 bus.busy, bus.trans_start, bus.read_row);
      end
    end
    bus.done_trans = 1'b0;
    for (int p = 0; p < 3; p++) begin
      load_random();
      launch();
      read_phase($urandom_range(2, MAXW), 1'b1, 1'b0);
      for (int i = 0; i < 4; i++) begin
        step();
        checks++;
        if (bus.busy !== 1'b0 || bus.trans_start !== 1'b0) begin
          errors++;
          $display("FAIL no_second_pass busy=%b trans_start=%b want 0 0", bus.busy, bus.trans_start);
        end
      end
    end
  endtask

  task automatic test_reset_mid_read();
    load_random();
    launch();
    step();
    bus.done_trans = 1'b1;
    step();
    bus.done_trans = 1'b0;
    step();
    step();
    step();
    checks++;
    if (bus.read_row !== RW'(3)) begin
      errors++;
      $display("FAIL mid_read_row got %0d want 3", bus.read_row);
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < FR; i++) exp_y[i] = 0;
    checks++;
    if (bus.busy !== 1'b0 || bus.read_row !== '0 || bus.done !== 1'b0 || bus.trans_start !== 1'b0) begin
      errors++;
      $display("FAIL mid_read_reset busy=%b read_row=%0d done=%b trans_start=%b want 0 0 0 0",
               bus.busy, bus.read_row, bus.done, bus.trans_start);
    end
    for (int i = 0; i < FR; i++) begin
      checks++;
      if (bus.y[i] !== '0) begin
        errors++;
        $display("FAIL mid_read_y row %0d got %0d want 0", i, bus.y[i]);
      end
    end
    for (int i = 0; i < 4; i++) begin
      step();
      checks++;
      if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL post_reset_idle done=%b busy=%b want 0 0", bus.done, bus.busy);
      end
    end
    load_random();
    launch();
    read_phase($urandom_range(0, MAXW), 1'b0, 1'b0);
  endtask

  task automatic test_back_to_back();
    load_random();
    launch();
    read_phase($urandom_range(0, MAXW), 1'b0, 1'b1);
    step();
    checks++;
    if (bus.busy !== 1'b1 || bus.trans_start !== 1'b1) begin
      errors++;
      $display("FAIL b2b_restart busy=%b trans_start=%b want 1 1", bus.busy, bus.trans_start);
    end
    load_random();
    read_phase($urandom_range(0, MAXW), 1'b0, 1'b0);
  endtask

`ifdef GCN_SEQ_TIMEOUT_EN
  task automatic test_watchdog();
    load_random();
    launch();
    for (int i = 2; i <= 16; i++) begin
      step();
      checks++;
      if (bus.trans_start !== 1'b1 || bus.error !== 1'b0) begin
        errors++;
        $display("FAIL wd_wait cyc %0d trans_start=%b error=%b want 1 0", i, bus.trans_start, bus.error);
      end
    end
    step();
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.error !== 1'b1 || bus.trans_start !== 1'b0 || bus.busy !== 1'b1 || bus.done !== 1'b0) begin
        errors++;
        $display("FAIL wd_error cyc %0d error=%b trans_start=%b busy=%b done=%b want 1 0 1 0",
                 i, bus.error, bus.trans_start, bus.busy, bus.done);
      end
      bus.done_trans = 1'($urandom_range(0, 1));
      bus.start = 1'($urandom_range(0, 1));
      step();
    end
    bus.done_trans = 1'b0;
    bus.start = 1'b0;
    for (int i = 0; i < FR; i++) begin
      checks++;
      if (bus.y[i] !== CW'(exp_y[i])) begin
        errors++;
        $display("FAIL wd_y_kept row %0d got %0d want %0d", i, bus.y[i], exp_y[i]);
      end
    end
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < FR; i++) exp_y[i] = 0;
    checks++;
    if (bus.error !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL wd_reset error=%b busy=%b want 0 0", bus.error, bus.busy);
    end
    load_random();
    launch();
    read_phase(15, 1'b0, 1'b0);
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.done_trans = 1'b0;
    load_random();
    test_reset();
    test_basic();
    test_ties();
    test_ignored_inputs();
    test_reset_mid_read();
    test_back_to_back();
`ifdef GCN_SEQ_TIMEOUT_EN
    test_watchdog();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
